// File: rtl/nor_gate_sw.sv
// nor_gate_sw: bitwise 2-input NOR with a clocked activity monitor.
// vout is purely combinational. The monitor registers vout, reports
// per-bit rising and falling edges, and keeps a saturating count of the
// edges on which any bit of vout changed.

// One bit of the NOR plus its registered copy and edge detectors.
module nor_gate_sw_lane (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic y,
    output logic y_q,
    output logic rise,
    output logic fall
);
    // X/Z on either operand is allowed to reach y unmasked.
    assign y = ~(a | b);

    // Register y and flag its transitions. Reset loads the NOR of idle-low inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= 1'b1;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            y_q  <= y;
            rise <= y & ~y_q;
            fall <= ~y & y_q;
        end
    end
endmodule

module nor_gate_sw #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] vin1,
    input  logic [WIDTH-1:0] vin2,
    output logic [WIDTH-1:0] vout,
    output logic [WIDTH-1:0] vout_q,
    output logic [WIDTH-1:0] vout_rise,
    output logic [WIDTH-1:0] vout_fall,
    output logic [CNT_W-1:0] toggle_cnt
);
    logic changed;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nor_gate_sw_lane u_lane (
            .clk  (clk),
            .rst  (rst),
            .a    (vin1[i]),
            .b    (vin2[i]),
            .y    (vout[i]),
            .y_q  (vout_q[i]),
            .rise (vout_rise[i]),
            .fall (vout_fall[i])
        );
    end

    // Any number of bits changing on one edge counts as a single transition.
    assign changed = |(vout ^ vout_q);

    // Saturating transition counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst)
            toggle_cnt <= '0;
        else if (changed && (toggle_cnt != {CNT_W{1'b1}}))
            toggle_cnt <= toggle_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_nor_gate_sw.sv
// Directed bench for nor_gate_sw: a default instance, a 2-bit-counter
// instance for saturation, and a 4-bit-wide instance for vector behaviour.
module tb_nor_gate_sw;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance (WIDTH=1, CNT_W=16)
    logic        a_rst, a_v1, a_v2, a_y, a_q, a_r, a_f;
    logic [15:0] a_cnt;
    nor_gate_sw #(.WIDTH(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .vin1(a_v1), .vin2(a_v2), .vout(a_y),
        .vout_q(a_q), .vout_rise(a_r), .vout_fall(a_f), .toggle_cnt(a_cnt));

    // Saturation instance (CNT_W=2)
    logic        s_rst, s_v1, s_v2, s_y, s_q, s_r, s_f;
    logic [1:0]  s_cnt;
    nor_gate_sw #(.WIDTH(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(s_rst), .vin1(s_v1), .vin2(s_v2), .vout(s_y),
        .vout_q(s_q), .vout_rise(s_r), .vout_fall(s_f), .toggle_cnt(s_cnt));

    // Wide instance (WIDTH=4)
    logic        w_rst;
    logic [3:0]  w_v1, w_v2, w_y, w_q, w_r, w_f;
    logic [15:0] w_cnt;
    nor_gate_sw #(.WIDTH(4), .CNT_W(16)) dut_w (
        .clk(clk), .rst(w_rst), .vin1(w_v1), .vin2(w_v2), .vout(w_y),
        .vout_q(w_q), .vout_rise(w_r), .vout_fall(w_f), .toggle_cnt(w_cnt));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle past it before touching anything.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic q_m, r_m, f_m;
    int   cnt_m;
    logic v_m;

    initial begin
        a_rst = 1'b1; a_v1 = 1'b0; a_v2 = 1'b0;
        s_rst = 1'b1; s_v1 = 1'b0; s_v2 = 1'b0;
        w_rst = 1'b1; w_v1 = 4'b0; w_v2 = 4'b0;

        // Reset held two cycles with idle inputs
        tick();
        chk("rst1_vout", a_y, 1);
        tick();
        chk("rst_vout_q", a_q, 1);
        chk("rst_rise", a_r, 0);
        chk("rst_fall", a_f, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_vout", a_y, 1);
        chk("rst_w_vout_q", w_q, 4'hF);
        chk("rst_s_cnt", s_cnt, 0);

        // Truth table, no clock edges between vectors
        a_v1 = 0; a_v2 = 0; #1 chk("tt_00", a_y, 1);
        a_v1 = 1; a_v2 = 0; #1 chk("tt_10", a_y, 0);
        a_v1 = 0; a_v2 = 1; #1 chk("tt_01", a_y, 0);
        a_v1 = 1; a_v2 = 1; #1 chk("tt_11", a_y, 0);
        a_v1 = 0; a_v2 = 0; #1 chk("tt_00b", a_y, 1);
        chk("tt_cnt_held_in_rst", a_cnt, 0);

        // Release reset; v1 toggles every 5 cycles, v2 every 10, for 60 cycles
        a_rst = 1'b0; s_rst = 1'b0; w_rst = 1'b0;
        q_m = 1'b1; cnt_m = 0;
        for (int i = 0; i < 60; i++) begin
            a_v1 = logic'((i / 5) % 2);
            a_v2 = logic'((i / 10) % 2);
            v_m  = ~(a_v1 | a_v2);
            tick();
            r_m = v_m & ~q_m;
            f_m = ~v_m & q_m;
            if (v_m != q_m) cnt_m++;
            q_m = v_m;
            chk("seq_q", a_q, q_m);
            chk("seq_rise", a_r, r_m);
            chk("seq_fall", a_f, f_m);
            chk("seq_cnt", a_cnt, cnt_m);
            chk("seq_excl", a_r & a_f, 0);
        end
        // Hand count: vout blocks 1,0,0,0,1,0,0,0,1,0,0,0 from q=1 -> 5 changes
        chk("seq_total", a_cnt, 5);

        // Glitch between edges is invisible to the monitor
        a_v1 = 1'b0; a_v2 = 1'b0;
        tick();
        chk("gl_pre_cnt", a_cnt, 6);
        #2 a_v1 = 1'b1;
        #1 chk("gl_vout", a_y, 0);
        #1 a_v1 = 1'b0;
        tick();
        chk("gl_cnt", a_cnt, 6);
        chk("gl_fall", a_f, 0);

        // Reset mid-activity, then resume counting
        a_v1 = 1'b1;
        tick();
        chk("mid_pre_cnt", a_cnt, 7);
        a_rst = 1'b1; a_v1 = 1'b0;
        #1 chk("mid_vout_in_rst", a_y, 1);
        a_v1 = 1'b1;
        #1 chk("mid_vout_in_rst2", a_y, 0);
        tick();
        chk("mid_cnt", a_cnt, 0);
        chk("mid_q", a_q, 1);
        chk("mid_rise", a_r, 0);
        chk("mid_fall", a_f, 0);
        a_rst = 1'b0;
        tick();
        chk("resume_cnt", a_cnt, 1);
        chk("resume_fall", a_f, 1);
        chk("resume_q", a_q, 0);

        // Saturation with CNT_W=2: vout 0,1,0,1,0 from q=1
        for (int i = 0; i < 5; i++) begin
            s_v1 = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            chk("sat_cnt", s_cnt, (i < 3) ? i + 1 : 3);
        end

        // Wide instance: vin1=0101, vin2=0011
        w_v1 = 4'b0101; w_v2 = 4'b0011;
        #1 chk("w_vout", w_y, 4'b1000);
        tick();
        chk("w_fall", w_f, 4'b0111);
        chk("w_rise", w_r, 4'b0000);
        chk("w_q", w_q, 4'b1000);
        chk("w_cnt", w_cnt, 1);
        w_v1 = 4'b0000; w_v2 = 4'b0000;
        tick();
        chk("w_rise2", w_r, 4'b0111);
        chk("w_fall2", w_f, 4'b0000);
        chk("w_cnt2", w_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
